mux4_rr_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one 4:1 data mux between four requesters.
- Owns the mux select and issues one-hot grants.
- Bounds each requester's tenure to MAX_HOLD cycles and steers the granted channel's data to a single output with a valid flag.
- Sits between four producer blocks and one shared downstream consumer.

---
 rtl/mux4_rr_arbiter.sv | 146 ++++++++++++++
 tb/tb_mux4_rr_arbiter.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter that owns a shared 4:1 data mux, with tenures capped at MAX_HOLD cycles.
// Optional per-channel tenure counters are compiled in with `define MUX_ARB_STATS_EN.
module mux4_rr_arbiter #(
  parameter int DW       = 8,
  parameter int MAX_HOLD = 4,
  parameter int CNT_W    = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [3:0]      req,
  input  logic [4*DW-1:0] din,
  output logic [3:0]      gnt,
  output logic [1:0]      sel,
  output logic [DW-1:0]   dout,
  output logic            dout_vld,
  output logic            busy
`ifdef MUX_ARB_STATS_EN
  ,
  input  logic              cnt_clr,
  output logic [4*CNT_W-1:0] gnt_cnt
`endif
);

  localparam int HW = $clog2(MAX_HOLD + 1);

  if (MAX_HOLD < 1 || CNT_W < 1) begin : g_bad_param
    $error("mux4_rr_arbiter: MAX_HOLD and CNT_W must be at least 1");
  end

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state_q, state_d;
  logic [3:0]      gnt_q, gnt_d;
  logic [1:0]      sel_q, sel_d;
  logic [1:0]      ptr_q, ptr_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic            load;
  logic [1:0]      win;
  logic [2:0]      arb;

  // Returns {found, index} of the first request at or after p, wrapping mod 4.
  function automatic logic [2:0] pick(input logic [3:0] r, input logic [1:0] p);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      idx = p + 2'(i);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    load    = 1'b0;
    win     = 2'd0;
    arb     = pick(req, ptr_q);
    case (state_q)
      IDLE: begin
        if (arb[2]) begin
          load    = 1'b1;
          win     = arb[1:0];
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (!req[sel_q] || hold_q == HW'(MAX_HOLD)) begin
          // Tenure over: the pointer moves past the outgoing owner before rearbitrating.
          ptr_d = sel_q + 2'd1;
          arb   = pick(req, sel_q + 2'd1);
          if (arb[2]) begin
            load = 1'b1;
            win  = arb[1:0];
          end else begin
            gnt_d   = '0;
            state_d = IDLE;
          end
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      gnt_d  = 4'b0001 << win;
      sel_d  = win;
      hold_d = HW'(1);
    end
  end

  always_comb begin
    busy     = (state_q == GRANT);
    dout_vld = (|gnt_q) && req[sel_q];
    dout     = '0;
    if (dout_vld) begin
      for (int i = 0; i < 4; i++) begin
        if (sel_q == 2'(i)) dout = din[i*DW +: DW];
      end
    end
  end

  assign gnt = gnt_q;
  assign sel = sel_q;

`ifdef MUX_ARB_STATS_EN
  logic [3:0][CNT_W-1:0] cnt_q, cnt_d;

  // Clear wins over a same-edge increment; counters stick at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (load && cnt_q[win] != {CNT_W{1'b1}}) begin
      cnt_d[win] = cnt_q[win] + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign gnt_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter: reset, contention, handover, short request, single requester.
module tb_mux4_rr_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req = 4'b0000;
  logic [31:0] din;
  logic [3:0]  gnt;
  logic [1:0]  sel;
  logic [7:0]  dout;
  logic        dout_vld;
  logic        busy;
`ifdef MUX_ARB_STATS_EN
  logic        cnt_clr = 1'b0;
  logic [31:0] gnt_cnt;
`endif

  int checks = 0;
  int failures = 0;
  logic [7:0] dv [4];

  mux4_rr_arbiter #(.DW(8), .MAX_HOLD(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .din(din),
    .gnt(gnt), .sel(sel), .dout(dout), .dout_vld(dout_vld), .busy(busy)
`ifdef MUX_ARB_STATS_EN
    , .cnt_clr(cnt_clr), .gnt_cnt(gnt_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int e;
    dv[0] = 8'h11; dv[1] = 8'h22; dv[2] = 8'hA5; dv[3] = 8'h44;
    din = {dv[3], dv[2], dv[1], dv[0]};

    // Reset state
    tick; tick;
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_sel", 32'(sel), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_vld", 32'(dout_vld), 32'h0);
    chk("rst_dout", 32'(dout), 32'h0);
    rst_n = 1'b1;
    tick;
    chk("idle_gnt", 32'(gnt), 32'h0);

    // Full contention from ptr=0
    req = 4'b1111;
    for (int c = 1; c <= 25; c++) begin
      tick;
      e = ((c - 1) / 4) % 4;
      chk($sformatf("cont_gnt_c%0d", c), 32'(gnt), 32'(4'b0001 << e));
      chk($sformatf("cont_sel_c%0d", c), 32'(sel), 32'(e));
      chk($sformatf("cont_vld_c%0d", c), 32'(dout_vld), 32'h1);
      chk($sformatf("cont_dout_c%0d", c), 32'(dout), 32'(dv[e]));
`ifdef MUX_ARB_STATS_EN
      if (c == 16) begin
        chk("cont_cnt16", gnt_cnt, 32'h01010101);
        cnt_clr = 1'b1;
      end
      if (c == 17) begin
        chk("cont_cnt_clr", gnt_cnt, 32'h0);
        cnt_clr = 1'b0;
      end
`endif
    end

    // Asynchronous reset mid-tenure (ch2 granted)
    #2 rst_n = 1'b0;
    #1;
    chk("arst_gnt", 32'(gnt), 32'h0);
    chk("arst_busy", 32'(busy), 32'h0);
    chk("arst_vld", 32'(dout_vld), 32'h0);
    chk("arst_dout", 32'(dout), 32'h0);
    chk("arst_sel", 32'(sel), 32'h0);
    req = 4'b0000;
    tick;
    rst_n = 1'b1;
    req = 4'b1010;
    tick;
    chk("ptr0_gnt", 32'(gnt), 32'h2);
    chk("ptr0_sel", 32'(sel), 32'h1);

    // Handover with no bubble
    req = 4'b0000;
    tick;
    chk("rel_gnt", 32'(gnt), 32'h0);
    chk("rel_busy", 32'(busy), 32'h0);
    chk("rel_sel_kept", 32'(sel), 32'h1);
    req = 4'b0001;
    tick;
    chk("ho_g0", 32'(gnt), 32'h1);
    tick;
    chk("ho_g0_hold2", 32'(gnt), 32'h1);
    req = 4'b1000;
    #1;
    chk("ho_drop_vld", 32'(dout_vld), 32'h0);
    chk("ho_drop_dout", 32'(dout), 32'h0);
    tick;
    chk("ho_gnt3", 32'(gnt), 32'h8);
    chk("ho_sel3", 32'(sel), 32'h3);
    chk("ho_busy", 32'(busy), 32'h1);
    chk("ho_vld", 32'(dout_vld), 32'h1);
    chk("ho_dout", 32'(dout), 32'h44);
    req = 4'b0011;
    tick;
    chk("ho_wrap_gnt0", 32'(gnt), 32'h1);
    chk("ho_wrap_dout", 32'(dout), 32'h11);
    req = 4'b0010;
    tick;
    chk("ho_next_gnt1", 32'(gnt), 32'h2);

    // Short request on ch1
    req = 4'b0000;
    tick;
    chk("sr_idle", 32'(gnt), 32'h0);
    req = 4'b0010;
    tick;
    chk("sr_gnt_c1", 32'(gnt), 32'h2);
    chk("sr_vld_c1", 32'(dout_vld), 32'h1);
    chk("sr_dout_c1", 32'(dout), 32'h22);
    din[15:8] = 8'h5A;
    #1;
    chk("sr_din_follow", 32'(dout), 32'h5A);
    tick;
    req = 4'b0000;
    #1;
    chk("sr_gnt_c2", 32'(gnt), 32'h2);
    chk("sr_vld_c2", 32'(dout_vld), 32'h0);
    chk("sr_dout_c2", 32'(dout), 32'h0);
    tick;
    chk("sr_gnt_c3", 32'(gnt), 32'h0);
    chk("sr_busy_c3", 32'(busy), 32'h0);

    // Single requester ch2, tenures restart every MAX_HOLD cycles
    req = 4'b0100;
    for (int c = 1; c <= 12; c++) begin
      tick;
      chk($sformatf("single_gnt_c%0d", c), 32'(gnt), 32'h4);
      chk($sformatf("single_sel_c%0d", c), 32'(sel), 32'h2);
      chk($sformatf("single_dout_c%0d", c), 32'(dout), 32'hA5);
      chk($sformatf("single_vld_c%0d", c), 32'(dout_vld), 32'h1);
`ifdef MUX_ARB_STATS_EN
      if (c == 12) chk("single_cnt2", 32'(gnt_cnt[23:16]), 32'h3);
`endif
    end
    req = 4'b0000;
    tick;
    chk("single_end_gnt", 32'(gnt), 32'h0);
    chk("single_end_busy", 32'(busy), 32'h0);
    chk("single_end_sel", 32'(sel), 32'h2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
